// File: rtl/set_bit_scanner.sv
// Set-bit scanner: emits the indices of the set bits of each accepted word, lowest first.
// Optional build macro SET_BIT_SCANNER_FLUSH_EN adds a flush input that aborts the current word.

module trailing_zeros #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // Scanning downward leaves the lowest set bit's index; an all-zero word reports WIDTH.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data[i]) begin
                count = CNT_W'(i);
            end
        end
    end

endmodule

// state | meaning
// IDLE  | no word held; in_ready high, out_valid low
// SCAN  | residual holds the unreported set bits; one beat presented per cycle
module set_bit_scanner #(
    parameter int DATA_WIDTH = 8,
    localparam int IDX_W = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SET_BIT_SCANNER_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic                  out_empty
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] residual_q, residual_d;
    logic                  empty_flag_q, empty_flag_d;

    logic                  flush_w;
    logic [DATA_WIDTH-1:0] residual_lsb_cleared;
    logic                  beat_hs;
    logic                  in_hs;

`ifdef SET_BIT_SCANNER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    trailing_zeros #(
        .WIDTH (DATA_WIDTH),
        .CNT_W (IDX_W)
    ) u_tz (
        .data  (residual_q),
        .count (out_index)
    );

    assign residual_lsb_cleared = residual_q & (residual_q - DATA_WIDTH'(1));

    // Outputs depend only on registers (plus flush); the out_ready -> in_ready path is deliberate.
    assign out_valid = (state_q == SCAN) && !flush_w;
    assign out_empty = empty_flag_q;
    assign out_last  = empty_flag_q || (residual_lsb_cleared == '0);
    assign beat_hs   = out_valid && out_ready;
    assign in_ready  = !flush_w && ((state_q == IDLE) || (beat_hs && out_last));
    assign in_hs     = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        residual_d   = residual_q;
        empty_flag_d = empty_flag_q;

        if (beat_hs) begin
            residual_d = residual_lsb_cleared;
            if (out_last) begin
                state_d = IDLE;
            end
        end

        // A new word overrides the return to IDLE so back-to-back words need no bubble.
        if (in_hs) begin
            residual_d   = in_data;
            empty_flag_d = (in_data == '0);
            state_d      = SCAN;
        end

        if (flush_w) begin
            state_d    = IDLE;
            residual_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            residual_q   <= '0;
            empty_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            residual_q   <= residual_d;
            empty_flag_q <= empty_flag_d;
        end
    end

endmodule
